// File: rtl/zigbee_pkg.sv
// Shared widths and slot-index type for the zigbee nibble datapath.
package zigbee_pkg;

    localparam int unsigned NIBBLE_W         = 4;
    localparam int unsigned WORD_W           = 16;
    localparam int unsigned NIBBLES_PER_WORD = 4;

    typedef logic [1:0] slot_t;

    localparam slot_t LAST_SLOT = slot_t'(NIBBLES_PER_WORD - 1);

endpackage

// File: rtl/nibble_packer_16.sv
// Packs 4-bit nibbles into 16-bit words (nibble k -> bits [4k+3:4k]) and
// offers each finished word downstream over valid/ready.
module nibble_packer_16
    import zigbee_pkg::*;
(
    input  logic                inClk,
    input  logic                inRst,
    input  logic                inClear,
    input  logic [NIBBLE_W-1:0] inData,
    input  logic                inValid,
    output logic                outReady,
    output logic [WORD_W-1:0]   outData,
    output logic                outValid,
    input  logic                inReady,
    output logic [1:0]          outCount
);

    localparam int unsigned ASM_W = (NIBBLES_PER_WORD - 1) * NIBBLE_W;

    slot_t             cnt;
    logic [ASM_W-1:0]  asm_q;
    logic [WORD_W-1:0] word_q;
    logic              word_valid_q;
    logic              accept;
    logic              load_word;

    // The last slot may only be taken when the output register is free or
    // draining this same cycle, hence the combinational inReady path.
    always_comb begin
        outReady  = 1'b0;
        accept    = 1'b0;
        load_word = 1'b0;
        outReady  = !inRst && !inClear &&
                    !((cnt == LAST_SLOT) && word_valid_q && !inReady);
        accept    = inValid && outReady;
        load_word = accept && (cnt == LAST_SLOT);
    end

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            cnt          <= '0;
            asm_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            if (inClear) begin
                cnt   <= '0;
                asm_q <= '0;
            end else if (accept) begin
                if (cnt == LAST_SLOT) begin
                    word_q <= {inData, asm_q};
                    cnt    <= '0;
                end else begin
                    for (int unsigned i = 0; i < NIBBLES_PER_WORD - 1; i++) begin
                        if (cnt == slot_t'(i))
                            asm_q[i*NIBBLE_W +: NIBBLE_W] <= inData;
                    end
                    cnt <= cnt + slot_t'(1);
                end
            end

            if (load_word)
                word_valid_q <= 1'b1;
            else if (inReady)
                word_valid_q <= 1'b0;
        end
    end

    assign outData  = word_q;
    assign outValid = word_valid_q;
    assign outCount = cnt;

endmodule

// File: tb/tb_nibble_packer_16.sv
// Directed and scoreboarded random checks for nibble_packer_16.
module tb_nibble_packer_16;

    logic        inClk = 1'b0;
    logic        inRst;
    logic        inClear;
    logic [3:0]  inData;
    logic        inValid;
    logic        outReady;
    logic [15:0] outData;
    logic        outValid;
    logic        inReady;
    logic [1:0]  outCount;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          mon_en  = 1'b0;
    logic [3:0]  sb_q[$];
    int unsigned sb_words = 0;

    nibble_packer_16 dut (
        .inClk    (inClk),
        .inRst    (inRst),
        .inClear  (inClear),
        .inData   (inData),
        .inValid  (inValid),
        .outReady (outReady),
        .outData  (outData),
        .outValid (outValid),
        .inReady  (inReady),
        .outCount (outCount)
    );

    always #5 inClk = ~inClk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    // Present one nibble, confirm it is acceptable, clock it in.
    task automatic push(input logic [3:0] nib, input string tag);
        inData  = nib;
        inValid = 1'b1;
        #1;
        check({tag, "_rdy"}, 16'(outReady), 16'd1);
        tick();
        inValid = 1'b0;
    endtask

    // Scoreboard: every accepted nibble queued, every transferred word checked.
    always @(negedge inClk) begin
        if (mon_en) begin
            if (outValid && inReady) begin
                check("sb_avail", 16'(sb_q.size() >= 4), 16'd1);
                if (sb_q.size() >= 4) begin
                    check("sb_word", outData, {sb_q[3], sb_q[2], sb_q[1], sb_q[0]});
                    repeat (4) void'(sb_q.pop_front());
                    sb_words++;
                end
            end
            if (inValid && outReady)
                sb_q.push_back(inData);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        inRst   = 1'b1;
        inClear = 1'b0;
        inData  = '0;
        inValid = 1'b0;
        inReady = 1'b0;
        repeat (2) tick();
        check("rst_valid", 16'(outValid), 16'd0);
        check("rst_data",  outData,       16'h0000);
        check("rst_count", 16'(outCount), 16'd0);
        check("rst_ready", 16'(outReady), 16'd0);
        inRst = 1'b0;
        #1;
        check("post_rst_ready", 16'(outReady), 16'd1);

        // Single word, outCount 1,2,3,0, valid for one cycle.
        inReady = 1'b1;
        push(4'h1, "t1_n1"); check("t1_cnt1", 16'(outCount), 16'd1);
        push(4'h2, "t1_n2"); check("t1_cnt2", 16'(outCount), 16'd2);
        push(4'h3, "t1_n3"); check("t1_cnt3", 16'(outCount), 16'd3);
        check("t1_novalid", 16'(outValid), 16'd0);
        push(4'h4, "t1_n4"); check("t1_cnt0", 16'(outCount), 16'd0);
        check("t1_valid", 16'(outValid), 16'd1);
        check("t1_word",  outData,       16'h4321);
        tick();
        check("t1_valid_drop", 16'(outValid), 16'd0);
        check("t1_hold",       outData,       16'h4321);

        // Back-to-back words.
        for (int i = 0; i < 8; i++) begin
            push(4'(i), "t2_n");
            if (i == 3) begin
                check("t2_v1", 16'(outValid), 16'd1);
                check("t2_w1", outData, 16'h3210);
            end else if (i == 7) begin
                check("t2_v2", 16'(outValid), 16'd1);
                check("t2_w2", outData, 16'h7654);
            end else begin
                check("t2_gap", 16'(outValid), 16'd0);
            end
        end
        tick();
        check("t2_drain", 16'(outValid), 16'd0);

        // Backpressure on the 4th nibble.
        inReady = 1'b0;
        push(4'h1, "t3_a"); push(4'h2, "t3_b"); push(4'h3, "t3_c"); push(4'h4, "t3_d");
        check("t3_w0", outData, 16'h4321);
        push(4'hA, "t3_A"); push(4'hB, "t3_B"); push(4'hC, "t3_C");
        check("t3_cnt3", 16'(outCount), 16'd3);
        check("t3_pend", 16'(outValid), 16'd1);
        inData  = 4'hD;
        inValid = 1'b1;
        #1;
        check("t3_stall", 16'(outReady), 16'd0);
        tick();
        check("t3_stall_cnt",  16'(outCount), 16'd3);
        check("t3_stall_data", outData,       16'h4321);
        inReady = 1'b1;
        #1;
        check("t3_release", 16'(outReady), 16'd1);
        tick();
        inValid = 1'b0;
        check("t3_w1",   outData,       16'hDCBA);
        check("t3_v1",   16'(outValid), 16'd1);
        check("t3_cnt0", 16'(outCount), 16'd0);
        tick();
        check("t3_drain", 16'(outValid), 16'd0);

        // Clear drops the partial word and the nibble presented with it.
        push(4'h5, "t4_5"); push(4'h6, "t4_6");
        inData  = 4'h7;
        inValid = 1'b1;
        inClear = 1'b1;
        #1;
        check("t4_clr_rdy", 16'(outReady), 16'd0);
        tick();
        inClear = 1'b0;
        inValid = 1'b0;
        check("t4_clr_cnt", 16'(outCount), 16'd0);
        push(4'h8, "t4_8"); push(4'h9, "t4_9"); push(4'hA, "t4_A"); push(4'hB, "t4_B");
        check("t4_v",    16'(outValid), 16'd1);
        check("t4_word", outData,       16'hBA98);
        tick();

        // Async reset mid-cycle with a pending word and a partial word.
        inReady = 1'b0;
        push(4'h1, "t5_1"); push(4'h2, "t5_2"); push(4'h3, "t5_3"); push(4'h4, "t5_4");
        push(4'h5, "t5_5"); push(4'h6, "t5_6");
        check("t5_pend", 16'(outValid), 16'd1);
        #3;
        inRst = 1'b1;
        #1;
        check("t5_rst_valid", 16'(outValid), 16'd0);
        check("t5_rst_cnt",   16'(outCount), 16'd0);
        check("t5_rst_data",  outData,       16'h0000);
        check("t5_rst_ready", 16'(outReady), 16'd0);
        tick();
        inRst   = 1'b0;
        inReady = 1'b1;
        push(4'h9, "t5_9"); push(4'hA, "t5_A"); push(4'hB, "t5_B"); push(4'hC, "t5_C");
        check("t5_v",    16'(outValid), 16'd1);
        check("t5_word", outData,       16'hCBA9);
        tick();

        // Random valid/ready against the scoreboard.
        mon_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            inData  = 4'($urandom_range(15, 0));
            inValid = ($urandom_range(3, 0) != 0);
            inReady = ($urandom_range(2, 0) != 0);
            tick();
        end
        inValid = 1'b0;
        inReady = 1'b1;
        repeat (3) tick();
        mon_en = 1'b0;
        check("rnd_drained",  16'(outValid),    16'd0);
        check("rnd_leftover", 16'(sb_q.size()), 16'(outCount));
        check("rnd_words",    16'(sb_words >= 20), 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
